decoder: RTL and testbench
==========================

Name: decoder

Overview:
- Instruction-decode (ID) stage of the 5-stage MIPS-style pipeline.
- Takes the IF/ID pipeline word (PC+4 and instruction).
- Decodes the instruction, reads the internal 32x32 register file, and extends the immediate.
- Registers everything into the 181-bit ID/EX pipeline word on each rising clock edge.

Parameters:
- None. Widths are fixed: 32-bit datapath, 32 registers.

Ports:
- clock  input  1  system clock, rising-edge active.
- reset_n  input  1  asynchronous, active-low reset.
- IF_ID  input  64  [63:32] = PC+4; [31:0] = instruction.
- wb_en  input  1  register-file write enable from the WB stage.
- wb_addr  input  5  register-file write address.
- wb_data  input  32  register-file write data.
- ID_EX  output  181  registered ID/EX pipeline word (layout below).

Behaviour:
- One clock; reset is asynchronous and active-low. While reset_n=0: ID_EX=0 and all 32 registers=0, independent of clock.
- ID_EX layout:
  - [180:149] pc_plus4 = IF_ID[63:32]
  - [148:117] rs_data
  - [116:85] rt_data
  - [84:53] imm32
  - [52:48] rs = instr[25:21]
  - [47:43] rt = instr[20:16]
  - [42:38] rd = instr[15:11]
  - [37:12] jtarget = instr[25:0]
  - [11:8] alu_ctrl
  - [7] reg_dst, [6] alu_src, [5] mem_to_reg, [4] reg_write, [3] mem_read, [2] mem_write, [1] branch, [0] jump
- Latency:
  - ID_EX reflects the IF_ID value present at the previous rising edge (1 cycle).
  - Decode and register-file read are combinational ahead of that register.
- Register file:
  - Two combinational read ports (rs, rt); one write port on the rising edge when wb_en=1.
  - $0 always reads 0; writes to $0 are ignored.
  - Write-first bypass: if wb_en=1 and wb_addr (nonzero) equals rs or rt, the read returns wb_data in the same cycle.
- Immediate: imm32 is instr[15:0] sign-extended, except for andi/ori, which zero-extend.
- ALU control encodings: AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, NOR=1100.
- Control decode by opcode (instr[31:26]):
  - 0x00 R-type: reg_dst=1, reg_write=1. alu_ctrl by funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x2A SLT. Any other funct: all control bits 0.
  - 0x23 lw: alu_src, mem_to_reg, reg_write, mem_read = 1; ADD.
  - 0x2B sw: alu_src, mem_write = 1; ADD.
  - 0x04 beq: branch=1; SUB.
  - 0x08 addi: alu_src, reg_write = 1; ADD.
  - 0x0A slti: alu_src, reg_write = 1; SLT.
  - 0x0C andi: alu_src, reg_write = 1; AND; zero-extend.
  - 0x0D ori: alu_src, reg_write = 1; OR; zero-extend.
  - 0x02 j: jump=1; alu_ctrl=0000.
  - Any other opcode: bubble, i.e. all 8 control bits and alu_ctrl = 0. Data fields (pc_plus4, register data, imm32, rs/rt/rd, jtarget) are still passed through.
- Reset mid-operation: ID_EX clears immediately on reset_n falling; registers clear; first capture after reset_n rises is at the next rising edge.
- IF_ID and the wb_* inputs are sampled only at rising edges. They must be driven to known values; X/Z in gives X out.

Test Plan:
- Reset + unknown opcode: reset_n=0, then IF_ID=64'hFFFF0000FFFF0000, release reset, one edge -> pc_plus4=FFFF0000, rs=31, rt=31, rd=0, rs_data=rt_data=0, imm32=0, jtarget=0x3FF0000, alu_ctrl=0, controls=0.
- Writeback + R-type with bypass: write $8=0x0000000A; then add $10,$8,$9 with wb_en=1, wb_addr=9, wb_data=5 in the same cycle -> rs_data=0xA, rt_data=5 (bypassed), rd=10, reg_dst=1, reg_write=1, alu_ctrl=0010.
- Immediate extension: lw $2,-4($8) (0x8D02FFFC) -> imm32=FFFFFFFC, alu_src/mem_to_reg/reg_write/mem_read=1. ori $2,$8,0xFFFC -> imm32=0000FFFC, alu_ctrl=0001.
- Branch/jump/store: beq (0x1109FFFF) -> branch=1, alu_ctrl=0110, imm32=FFFFFFFF. j 0x0800004 -> jump=1, jtarget=0x0800004. sw -> mem_write=1, reg_write=0.
- $0 protection: write wb_addr=0, wb_data=DEADBEEF; read $0 -> 0. Unknown funct 0x3F under opcode 0 -> controls=0.
- Async reset mid-stream: assert reset_n between edges -> ID_EX=0 before the next edge; registers previously written read 0 afterwards.

Source files
------------

// File: rtl/decoder.sv
// ID stage: decodes the IF/ID word, reads the 32x32 register file with write-first bypass, and extends the immediate.
// One cycle from IF_ID to ID_EX. There is no backpressure: the stage captures on every rising edge.
module decoder (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [63:0]  IF_ID,
    input  logic         wb_en,
    input  logic [4:0]   wb_addr,
    input  logic [31:0]  wb_data,
    output logic [180:0] ID_EX
);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    logic [31:0]  w_instr;
    logic [5:0]   w_op;
    logic [5:0]   w_funct;
    logic [4:0]   w_rs;
    logic [4:0]   w_rt;
    logic [4:0]   w_rd;
    logic [31:0]  w_rs_data;
    logic [31:0]  w_rt_data;
    logic [31:0]  w_imm32;
    logic [3:0]   w_alu_ctrl;
    logic [7:0]   w_ctrl;
    logic         w_zero_ext;
    logic [180:0] w_id_ex;

    logic [31:0]  r_regs [32];
    logic [180:0] r_id_ex;

    assign w_instr = IF_ID[31:0];
    assign w_op    = w_instr[31:26];
    assign w_funct = w_instr[5:0];
    assign w_rs    = w_instr[25:21];
    assign w_rt    = w_instr[20:16];
    assign w_rd    = w_instr[15:11];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_en && (wb_addr != 5'd0)) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    // Write-first: a same-cycle writeback to a source register is forwarded.
    always_comb begin
        w_rs_data = r_regs[w_rs];
        w_rt_data = r_regs[w_rt];
        if (w_rs == 5'd0) begin
            w_rs_data = '0;
        end else if (wb_en && (wb_addr == w_rs)) begin
            w_rs_data = wb_data;
        end
        if (w_rt == 5'd0) begin
            w_rt_data = '0;
        end else if (wb_en && (wb_addr == w_rt)) begin
            w_rt_data = wb_data;
        end
    end

    // w_ctrl = {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump}
    always_comb begin
        w_ctrl     = 8'h00;
        w_alu_ctrl = ALU_AND;
        w_zero_ext = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                w_ctrl = 8'b1001_0000;
                case (w_funct)
                    6'h20:   w_alu_ctrl = ALU_ADD;
                    6'h22:   w_alu_ctrl = ALU_SUB;
                    6'h24:   w_alu_ctrl = ALU_AND;
                    6'h25:   w_alu_ctrl = ALU_OR;
                    6'h27:   w_alu_ctrl = ALU_NOR;
                    6'h2A:   w_alu_ctrl = ALU_SLT;
                    default: w_ctrl     = 8'h00;
                endcase
            end
            OP_LW: begin
                w_ctrl     = 8'b0111_1000;
                w_alu_ctrl = ALU_ADD;
            end
            OP_SW: begin
                w_ctrl     = 8'b0100_0100;
                w_alu_ctrl = ALU_ADD;
            end
            OP_BEQ: begin
                w_ctrl     = 8'b0000_0010;
                w_alu_ctrl = ALU_SUB;
            end
            OP_ADDI: begin
                w_ctrl     = 8'b0101_0000;
                w_alu_ctrl = ALU_ADD;
            end
            OP_SLTI: begin
                w_ctrl     = 8'b0101_0000;
                w_alu_ctrl = ALU_SLT;
            end
            OP_ANDI: begin
                w_ctrl     = 8'b0101_0000;
                w_alu_ctrl = ALU_AND;
                w_zero_ext = 1'b1;
            end
            OP_ORI: begin
                w_ctrl     = 8'b0101_0000;
                w_alu_ctrl = ALU_OR;
                w_zero_ext = 1'b1;
            end
            OP_J: begin
                w_ctrl     = 8'b0000_0001;
            end
            default: begin
                w_ctrl     = 8'h00;
            end
        endcase
    end

    assign w_imm32 = w_zero_ext ? {16'h0000, w_instr[15:0]} : {{16{w_instr[15]}}, w_instr[15:0]};

    assign w_id_ex = {IF_ID[63:32], w_rs_data, w_rt_data, w_imm32,
                      w_rs, w_rt, w_rd, w_instr[25:0], w_alu_ctrl, w_ctrl};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_id_ex <= '0;
        end else begin
            r_id_ex <= w_id_ex;
        end
    end

    assign ID_EX = r_id_ex;

endmodule

// File: tb/tb_decoder.sv
// Bench for the ID stage: directed vector table, async-reset sequence, then random stimulus against a reference model.
module tb_decoder;

    logic         clock;
    logic         reset_n;
    logic [63:0]  IF_ID;
    logic         wb_en;
    logic [4:0]   wb_addr;
    logic [31:0]  wb_data;
    logic [180:0] ID_EX;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] m_regs [32];

    decoder dut (
        .clock   (clock),
        .reset_n (reset_n),
        .IF_ID   (IF_ID),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .ID_EX   (ID_EX)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [25:0] jt;
        logic [3:0]  alu;
        logic [7:0]  ctl;
    } vec_t;

    function automatic logic [180:0] pack(vec_t v);
        return {v.pc, v.rsd, v.rtd, v.imm, v.rs, v.rt, v.rd, v.jt, v.alu, v.ctl};
    endfunction

    task automatic check(input string name, input logic [180:0] act, input logic [180:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference: apply the writeback first, then read (write-first semantics), then look up the mnemonic's properties.
    function automatic logic [180:0] model(input logic [63:0] ifid);
        logic [31:0] ins;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [3:0]  alu;
        logic [7:0]  ctl;
        logic        zx;
        logic [31:0] imm;
        ins = ifid[31:0];
        op  = ins[31:26];
        fn  = ins[5:0];
        alu = 4'b0000;
        ctl = 8'h00;
        zx  = 1'b0;
        if (op == 6'h00) begin
            if      (fn == 6'h20) begin alu = 4'b0010; ctl = 8'h90; end
            else if (fn == 6'h22) begin alu = 4'b0110; ctl = 8'h90; end
            else if (fn == 6'h24) begin alu = 4'b0000; ctl = 8'h90; end
            else if (fn == 6'h25) begin alu = 4'b0001; ctl = 8'h90; end
            else if (fn == 6'h27) begin alu = 4'b1100; ctl = 8'h90; end
            else if (fn == 6'h2A) begin alu = 4'b0111; ctl = 8'h90; end
        end
        else if (op == 6'h23) begin alu = 4'b0010; ctl = 8'h78; end
        else if (op == 6'h2B) begin alu = 4'b0010; ctl = 8'h44; end
        else if (op == 6'h04) begin alu = 4'b0110; ctl = 8'h02; end
        else if (op == 6'h08) begin alu = 4'b0010; ctl = 8'h50; end
        else if (op == 6'h0A) begin alu = 4'b0111; ctl = 8'h50; end
        else if (op == 6'h0C) begin alu = 4'b0000; ctl = 8'h50; zx = 1'b1; end
        else if (op == 6'h0D) begin alu = 4'b0001; ctl = 8'h50; zx = 1'b1; end
        else if (op == 6'h02) begin alu = 4'b0000; ctl = 8'h01; end
        imm = zx ? {16'h0, ins[15:0]} : 32'(signed'(ins[15:0]));
        return {ifid[63:32], m_regs[ins[25:21]], m_regs[ins[20:16]], imm,
                ins[25:21], ins[20:16], ins[15:11], ins[25:0], alu, ctl};
    endfunction

    task automatic rstep(input string name, input logic [63:0] ifid, input logic en,
                         input logic [4:0] a, input logic [31:0] d);
        logic [180:0] exp;
        IF_ID   = ifid;
        wb_en   = en;
        wb_addr = a;
        wb_data = d;
        if (en && a != 5'd0) m_regs[a] = d;
        exp = model(ifid);
        @(posedge clock);
        #1;
        check(name, ID_EX, exp);
    endtask

    vec_t       tbl [13];
    logic [5:0] ops [11];
    logic [5:0] fns [7];

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = '0;

        //            pc          instr        en  addr   data          rsd           rtd    imm           rs  rt  rd  jt           alu      ctl
        tbl[0]  = '{32'hFFFF0000, 32'hFFFF0000, 0, 5'd0, 32'h0,        32'h0,        32'h0, 32'h00000000, 31, 31, 0,  26'h3FF0000, 4'b0000, 8'h00};
        tbl[1]  = '{32'h00000004, 32'h00000000, 1, 5'd8, 32'h0000000A, 32'h0,        32'h0, 32'h00000000, 0,  0,  0,  26'h0000000, 4'b0000, 8'h00};
        tbl[2]  = '{32'h00000008, 32'h01095020, 1, 5'd9, 32'h00000005, 32'hA,        32'h5, 32'h00005020, 8,  9,  10, 26'h1095020, 4'b0010, 8'h90};
        tbl[3]  = '{32'h0000000C, 32'h8D02FFFC, 0, 5'd0, 32'h0,        32'hA,        32'h0, 32'hFFFFFFFC, 8,  2,  31, 26'h102FFFC, 4'b0010, 8'h78};
        tbl[4]  = '{32'h00000010, 32'h3502FFFC, 0, 5'd0, 32'h0,        32'hA,        32'h0, 32'h0000FFFC, 8,  2,  31, 26'h102FFFC, 4'b0001, 8'h50};
        tbl[5]  = '{32'h00000014, 32'h1109FFFF, 0, 5'd0, 32'h0,        32'hA,        32'h5, 32'hFFFFFFFF, 8,  9,  31, 26'h109FFFF, 4'b0110, 8'h02};
        tbl[6]  = '{32'h00000018, 32'h08800004, 0, 5'd0, 32'h0,        32'h0,        32'h0, 32'h00000004, 4,  0,  0,  26'h0800004, 4'b0000, 8'h01};
        tbl[7]  = '{32'h0000001C, 32'hAD090008, 0, 5'd0, 32'h0,        32'hA,        32'h5, 32'h00000008, 8,  9,  0,  26'h1090008, 4'b0010, 8'h44};
        tbl[8]  = '{32'h00000020, 32'h00001820, 1, 5'd0, 32'hDEADBEEF, 32'h0,        32'h0, 32'h00001820, 0,  0,  3,  26'h0001820, 4'b0010, 8'h90};
        tbl[9]  = '{32'h00000024, 32'h0000183F, 0, 5'd0, 32'h0,        32'h0,        32'h0, 32'h0000183F, 0,  0,  3,  26'h000183F, 4'b0000, 8'h00};
        tbl[10] = '{32'h00000028, 32'h31048001, 0, 5'd0, 32'h0,        32'hA,        32'h0, 32'h00008001, 8,  4,  16, 26'h1048001, 4'b0000, 8'h50};
        tbl[11] = '{32'h0000002C, 32'h2904FFFF, 0, 5'd0, 32'h0,        32'hA,        32'h0, 32'hFFFFFFFF, 8,  4,  31, 26'h104FFFF, 4'b0111, 8'h50};
        tbl[12] = '{32'h00000030, 32'h21247FFF, 0, 5'd0, 32'h0,        32'h5,        32'h0, 32'h00007FFF, 9,  4,  15, 26'h1247FFF, 4'b0010, 8'h50};

        ops = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h02, 6'h00};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00};

        reset_n = 1'b0;
        IF_ID   = 64'hFFFF0000FFFF0000;
        wb_en   = 1'b1;
        wb_addr = 5'd31;
        wb_data = 32'h12345678;
        #1;
        check("reset_state", ID_EX, '0);
        @(posedge clock);
        #1;
        check("reset_held_over_edge", ID_EX, '0);
        @(negedge clock);
        wb_en   = 1'b0;
        wb_addr = 5'd0;
        wb_data = 32'h0;
        reset_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            IF_ID   = {tbl[i].pc, tbl[i].instr};
            wb_en   = tbl[i].en;
            wb_addr = tbl[i].addr;
            wb_data = tbl[i].data;
            @(posedge clock);
            #1;
            check($sformatf("vec%0d", i), ID_EX, pack(tbl[i]));
        end

        // Async reset between edges, with a writeback pending that must not land.
        IF_ID   = {32'h00000034, 32'h01095020};
        wb_en   = 1'b1;
        wb_addr = 5'd8;
        wb_data = 32'h00000077;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_clears", ID_EX, '0);
        @(posedge clock);
        #1;
        check("reset_blocks_capture", ID_EX, '0);
        @(negedge clock);
        reset_n = 1'b1;
        wb_en   = 1'b0;
        #1;
        check("no_capture_before_edge", ID_EX, '0);
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        rstep("regs_cleared_after_reset", {32'h00000038, 32'h1109FFFF}, 1'b0, 5'd0, 32'h0);
        check("rs_rt_zero_after_reset", ID_EX[148:85], 64'h0);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] ins;
            logic [5:0]  op;
            logic [4:0]  a;
            int unsigned k;
            ins = $urandom;
            k   = $urandom_range(0, 11);
            op  = (k == 11) ? 6'($urandom_range(0, 63)) : ops[k];
            ins[31:26] = op;
            if (op == 6'h00 && $urandom_range(0, 3) != 0) ins[5:0] = fns[$urandom_range(0, 5)];
            case ($urandom_range(0, 3))
                0:       a = ins[25:21];
                1:       a = ins[20:16];
                default: a = 5'($urandom_range(0, 31));
            endcase
            rstep("rand", {$urandom, ins}, 1'($urandom_range(0, 1)), a, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
